// File: rtl/bk_reg_seq_pkg.sv
// Shared encodings and sizes for the backend register configuration sequencer.
package bk_reg_seq_pkg;

  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_REQ    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

endpackage

// File: rtl/bk_seq_timer.sv
// Clearable up-counter with terminal-count compare, shared by the write
// timeout and the settle delay.
module bk_seq_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/bk_reg_seq.sv
// Walks register indices 0..15 and writes each masked-in register to the
// backend over a req/ack handshake, then settles and pulses done.
module bk_reg_seq
  import bk_reg_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned SETTLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ap_start_pedge,
  input  logic [NUM_REGS-1:0] cfg_mask_i,
  output logic [IDX_W-1:0]    reg_rd_idx_o,
  input  logic [31:0]         reg_rd_data_i,
  output logic                wr_req_o,
  output logic [IDX_W-1:0]    wr_addr_o,
  output logic [31:0]         wr_data_o,
  input  logic                wr_ack_i,
  output logic                ap_busy_o,
  output logic                ap_done_o,
  output logic                ap_err_o,
  output logic [IDX_W-1:0]    err_idx_o,
  output logic [4:0]          wr_cnt_o
);

  localparam logic [CNT_W-1:0] TO_TERM     = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYCLES - 1);
  // A zero settle period bypasses SETTLE entirely.
  localparam state_t END_STATE = (SETTLE_CYCLES == 0) ? ST_DONE : ST_SETTLE;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_REGS-1:0] mask_q;
  logic [IDX_W-1:0]    wr_addr_q, err_idx_q;
  logic [31:0]         wr_data_q;
  logic                wr_req_q, busy_q, done_q, err_q;
  logic [4:0]          wr_cnt_q;

  logic             tmr_clr, tmr_inc, tmr_tc;
  logic [CNT_W-1:0] tmr_term;
  logic             start_acc, capture, ack_acc, timeout;

  bk_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .term  (tmr_term),
    .tc    (tmr_tc)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    tmr_term  = TO_TERM;
    start_acc = 1'b0;
    capture   = 1'b0;
    ack_acc   = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ap_start_pedge) begin
          start_acc = 1'b1;
          idx_d     = '0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (mask_q[idx_q]) begin
          capture = 1'b1;
          tmr_clr = 1'b1;
          state_d = ST_REQ;
        end else if (idx_q == LAST_IDX) begin
          tmr_clr = 1'b1;
          state_d = END_STATE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_REQ: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (wr_ack_i) begin
          ack_acc = 1'b1;
          if (idx_q == LAST_IDX) begin
            tmr_clr = 1'b1;
            state_d = END_STATE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SCAN;
          end
        end else if (tmr_tc) begin
          timeout = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_SETTLE: begin
        tmr_term = SETTLE_TERM;
        if (tmr_tc) begin
          state_d = ST_DONE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_req_q <= (state_d == ST_REQ);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      if (start_acc) begin
        mask_q    <= cfg_mask_i;
        wr_cnt_q  <= '0;
        err_q     <= 1'b0;
        err_idx_q <= '0;
      end
      if (capture) begin
        wr_addr_q <= idx_q;
        wr_data_q <= reg_rd_data_i;
      end
      if (ack_acc) begin
        wr_cnt_q <= wr_cnt_q + 5'd1;
      end
      if (timeout) begin
        err_q     <= 1'b1;
        err_idx_q <= idx_q;
      end
    end
  end

  assign reg_rd_idx_o = idx_q;
  assign wr_req_o     = wr_req_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign ap_busy_o    = busy_q;
  assign ap_done_o    = done_q;
  assign ap_err_o     = err_q;
  assign err_idx_o    = err_idx_q;
  assign wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_bk_reg_seq.sv
// Bench for bk_reg_seq: two instances (settle 4 and settle 0) run in lockstep
// against a cycle-count model of the sequence and a scripted backend.
module tb_bk_reg_seq;

  localparam int ND = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] mask;
  logic [31:0] rd_base;

  logic [3:0]  rd_idx  [ND];
  logic [31:0] rd_data [ND];
  logic        wr_req  [ND];
  logic [3:0]  wr_addr [ND];
  logic [31:0] wr_data [ND];
  logic        ack     [ND];
  logic        busy    [ND];
  logic        done    [ND];
  logic        err     [ND];
  logic [3:0]  err_idx [ND];
  logic [4:0]  wr_cnt  [ND];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Backend script and monitor records.
  int          ack_delay;
  int          blk_idx;
  logic        mon_clr;
  int          hi_cnt    [ND];
  int          req_cyc   [ND];
  int          unstable  [ND];
  int          busy_cyc  [ND];
  int          done_n    [ND];
  int          done_cyc  [ND];
  logic        done_err  [ND];
  logic [3:0]  done_eidx [ND];
  logic [4:0]  done_cnt  [ND];
  int          log_n     [ND];
  logic [3:0]  log_addr  [ND][16];
  logic [31:0] log_data  [ND][16];
  logic [3:0]  prev_addr [ND];
  logic [31:0] prev_data [ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rd_data[0] = rd_base ^ {28'h0, rd_idx[0]};
  assign rd_data[1] = rd_base ^ {28'h0, rd_idx[1]};

  bk_reg_seq #(.TIMEOUT(TO), .SETTLE_CYCLES(4), .CNT_W(16)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .ap_start_pedge(start), .cfg_mask_i(mask),
    .reg_rd_idx_o(rd_idx[0]), .reg_rd_data_i(rd_data[0]), .wr_req_o(wr_req[0]),
    .wr_addr_o(wr_addr[0]), .wr_data_o(wr_data[0]), .wr_ack_i(ack[0]),
    .ap_busy_o(busy[0]), .ap_done_o(done[0]), .ap_err_o(err[0]),
    .err_idx_o(err_idx[0]), .wr_cnt_o(wr_cnt[0])
  );

  bk_reg_seq #(.TIMEOUT(TO), .SETTLE_CYCLES(0), .CNT_W(16)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .ap_start_pedge(start), .cfg_mask_i(mask),
    .reg_rd_idx_o(rd_idx[1]), .reg_rd_data_i(rd_data[1]), .wr_req_o(wr_req[1]),
    .wr_addr_o(wr_addr[1]), .wr_data_o(wr_data[1]), .wr_ack_i(ack[1]),
    .ap_busy_o(busy[1]), .ap_done_o(done[1]), .ap_err_o(err[1]),
    .err_idx_o(err_idx[1]), .wr_cnt_o(wr_cnt[1])
  );

  // Backend: acks after ack_delay request cycles, never acks blk_idx.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        ack[d]    = 1'b0;
        hi_cnt[d] = 0;
      end else if (mon_clr) begin
        req_cyc[d] = 0; unstable[d] = 0; busy_cyc[d] = 0;
        done_n[d] = 0; done_cyc[d] = 0; log_n[d] = 0;
        done_err[d] = 1'b0; done_eidx[d] = '0; done_cnt[d] = '0;
      end else begin
        if (wr_req[d]) begin
          ack[d] = (hi_cnt[d] >= ack_delay) && (int'(wr_addr[d]) != blk_idx);
          if (hi_cnt[d] > 0 && (wr_addr[d] != prev_addr[d] || wr_data[d] != prev_data[d]))
            unstable[d]++;
          prev_addr[d] = wr_addr[d];
          prev_data[d] = wr_data[d];
          hi_cnt[d]++;
          req_cyc[d]++;
          if (ack[d] && log_n[d] < 16) begin
            log_addr[d][log_n[d]] = wr_addr[d];
            log_data[d][log_n[d]] = wr_data[d];
            log_n[d]++;
          end
        end else begin
          ack[d]    = 1'b0;
          hi_cnt[d] = 0;
        end
        if (busy[d]) busy_cyc[d]++;
        if (done[d]) begin
          done_n[d]++;
          done_cyc[d]  = cyc;
          done_err[d]  = err[d];
          done_eidx[d] = err_idx[d];
          done_cnt[d]  = wr_cnt[d];
        end
      end
    end
  end

  // Expected outcome from cycle accounting: 1 start cycle, 1 per SCAN,
  // (wait+1) per acked write, TO on a timeout (abort), then settle.
  task automatic model(input logic [15:0] m, input int dly, input int blk, input int settle,
                       output int lat, output int nw, output logic e, output int eidx,
                       output int reqc);
    int t;
    t = 1; nw = 0; e = 1'b0; eidx = 0; reqc = 0;
    for (int i = 0; i < 16; i++) begin
      if (!e) begin
        t++;
        if (m[i]) begin
          if (i == blk || dly > TO - 1) begin
            e = 1'b1; eidx = i; reqc += TO; t += TO;
          end else begin
            reqc += dly + 1; t += dly + 1; nw++;
          end
        end
      end
    end
    lat = e ? t : t + settle;
  endtask

  task automatic run_and_compare(input string name, input logic [15:0] m, input int dly,
                                 input int blk, input bit extra_start);
    int t0, lat, nw, eidx, reqc, k, budget, settle;
    logic e;
    ack_delay = dly;
    blk_idx   = blk;
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
    @(negedge clk); start = 1'b1; mask = m; t0 = cyc;
    @(negedge clk); start = 1'b0; mask = 16'($urandom);
    budget = 0;
    while (!(done_n[0] > 0 && done_n[1] > 0) && budget < 2000) begin
      start = (extra_start && budget == 4);
      if (start) mask = 16'($urandom);
      @(negedge clk);
      budget++;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (budget >= 2000) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, budget);
    end
    for (int d = 0; d < ND; d++) begin
      settle = (d == 0) ? 4 : 0;
      model(m, dly, blk, settle, lat, nw, e, eidx, reqc);
      checks++;
      if (done_n[d] != 1) begin
        errors++; $display("FAIL %s dut%0d done_count: got %0d want 1", name, d, done_n[d]);
      end
      checks++;
      if (done_cyc[d] != t0 + lat) begin
        errors++; $display("FAIL %s dut%0d done_latency: got %0d want %0d", name, d, done_cyc[d] - t0, lat);
      end
      checks++;
      if (done_err[d] !== e || err[d] !== e) begin
        errors++; $display("FAIL %s dut%0d err: got %0b/%0b want %0b", name, d, done_err[d], err[d], e);
      end
      if (e) begin
        checks++;
        if (int'(done_eidx[d]) != eidx) begin
          errors++; $display("FAIL %s dut%0d err_idx: got %0d want %0d", name, d, done_eidx[d], eidx);
        end
      end
      checks++;
      if (int'(done_cnt[d]) != nw || int'(wr_cnt[d]) != nw) begin
        errors++; $display("FAIL %s dut%0d wr_cnt: got %0d want %0d", name, d, done_cnt[d], nw);
      end
      checks++;
      if (log_n[d] != nw) begin
        errors++; $display("FAIL %s dut%0d writes: got %0d want %0d", name, d, log_n[d], nw);
      end
      k = 0;
      for (int i = 0; i < 16; i++) begin
        if (m[i] && k < nw) begin
          checks++;
          if (log_addr[d][k] !== 4'(i) || log_data[d][k] !== (rd_base ^ 32'(i))) begin
            errors++;
            $display("FAIL %s dut%0d write%0d: got addr %0d data %h want addr %0d data %h",
                     name, d, k, log_addr[d][k], log_data[d][k], i, rd_base ^ 32'(i));
          end
          k++;
        end
      end
      checks++;
      if (req_cyc[d] != reqc || unstable[d] != 0) begin
        errors++;
        $display("FAIL %s dut%0d req: got %0d high cycles (%0d unstable) want %0d stable",
                 name, d, req_cyc[d], unstable[d], reqc);
      end
      checks++;
      if (busy_cyc[d] != lat || busy[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s dut%0d busy: got %0d cycles now %0b want %0d cycles now 0",
                 name, d, busy_cyc[d], busy[d], lat);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (wr_req[d] !== 1'b0 || busy[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0 ||
          wr_addr[d] !== 4'h0 || wr_data[d] !== 32'h0 || err_idx[d] !== 4'h0 ||
          wr_cnt[d] !== 5'h0 || rd_idx[d] !== 4'h0) begin
        errors++;
        $display("FAIL reset dut%0d: req %b busy %b done %b err %b addr %h data %h eidx %h cnt %h idx %h want all 0",
                 d, wr_req[d], busy[d], done[d], err[d], wr_addr[d], wr_data[d],
                 err_idx[d], wr_cnt[d], rd_idx[d]);
      end
    end
  endtask

  task automatic test_single_write();
    rd_base = 32'hA5A5_0000;
    run_and_compare("single_write", 16'h0001, 0, 16, 1'b0);
  endtask

  task automatic test_all_delayed();
    rd_base = $urandom;
    run_and_compare("all_delayed", 16'hFFFF, 3, 16, 1'b0);
  endtask

  task automatic test_timeout();
    rd_base = $urandom;
    run_and_compare("timeout", 16'h0104, 0, 8, 1'b0);
  endtask

  task automatic test_zero_mask();
    rd_base = $urandom;
    run_and_compare("zero_mask", 16'h0000, 0, 16, 1'b0);
  endtask

  task automatic test_busy_start_ack_at_timeout();
    rd_base = $urandom;
    run_and_compare("ack_at_timeout", 16'h8421 | 16'($urandom), TO - 1, 16, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      rd_base = $urandom;
      run_and_compare("random", 16'($urandom), int'($urandom_range(0, TO - 1)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 16,
                      1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_req();
    int n;
    ack_delay = TO - 1;
    blk_idx   = 16;
    rd_base   = $urandom;
    @(negedge clk); start = 1'b1; mask = 16'h0010;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!wr_req[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_req[0] !== 1'b1) begin
      errors++; $display("FAIL reset_mid_req reach_req: got req %b want 1", wr_req[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (wr_req[d] !== 1'b0 || busy[d] !== 1'b0 || wr_cnt[d] !== 5'h0) begin
        errors++;
        $display("FAIL reset_mid_req dut%0d: req %b busy %b cnt %0d want 0 0 0",
                 d, wr_req[d], busy[d], wr_cnt[d]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    rd_base = $urandom;
    run_and_compare("after_reset", 16'h0F0F, 1, 16, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mask = '0; rd_base = '0;
    mon_clr = 1'b0; ack_delay = 0; blk_idx = 16;
    #1;
    test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_single_write();
    test_all_delayed();
    test_timeout();
    test_zero_mask();
    test_busy_start_ack_at_timeout();
    test_random();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
